// File: rtl/fifo_16_wr_arb.sv
// fifo_16_wr_arb: packet-granular round-robin arbiter for the single write
// port of a fifo_16. It tracks FIFO occupancy itself, using the consumer's read strobe.
// Optional feature: define FIFO_ARB_TIMEOUT_EN to release an owner that
// leaves req low for TMO consecutive cycles in the middle of a packet.
module fifo_16_wr_arb #(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 9,
  parameter int DEPTH  = 512,
  parameter int LVLW   = 10,
  parameter int TMO    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        last,
  input  logic [NREQ*AWIDTH-1:0] din,
  output logic [NREQ-1:0]        ack,
  output logic                   fifo_wr_en,
  output logic [AWIDTH-1:0]      fifo_din,
  input  logic                   fifo_rd_en,
  output logic [LVLW-1:0]        level,
  output logic                   empty,
  output logic                   full,
  output logic                   udf_err,
  output logic                   tmo_err
);

  localparam int OWW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Catch illegal parameter sets at elaboration time.
  if (TMO < 1 || (1 << LVLW) <= DEPTH || NREQ < 2 || NREQ > 8) begin : g_bad_param
    $error("fifo_16_wr_arb: illegal parameter combination");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [OWW-1:0]      owner_q, owner_d;
  logic [OWW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [OWW-1:0]      winner, owner_inc;
  logic                any_req;
  logic [LVLW-1:0]     level_q, level_d;
  logic                fifo_wr_en_q, fifo_wr_en_d;
  logic [AWIDTH-1:0]   fifo_din_q, fifo_din_d;
  logic                udf_err_q, udf_err_d;
  logic                full_now, full_next, accept, rd_ok;
  logic [AWIDTH-1:0]   din_arr [NREQ];

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                tmo_err_q, tmo_err_d;
`endif

  // Unpack the flat requester data bus into one word per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_din
    assign din_arr[gi] = din[gi*AWIDTH +: AWIDTH];
  end

  assign full_now  = (level_q == LVLW'(DEPTH));
  // A read in this cycle frees a slot, so a full FIFO can still take a word.
  assign full_next = full_now & ~fifo_rd_en;
  assign rd_ok     = fifo_rd_en & (level_q != '0);
  assign owner_inc = (owner_q == OWW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // Round-robin search starting at rr_ptr; scanning downwards lets the
  // closest requester to rr_ptr overwrite any farther one.
  always_comb begin
    int idx;
    winner  = rr_ptr_q;
    any_req = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[OWW'(idx)]) begin
        winner  = OWW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Next-state, grant, write-path and occupancy logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    ack          = '0;
    accept       = 1'b0;
    fifo_wr_en_d = 1'b0;
    fifo_din_d   = fifo_din_q;
`ifdef FIFO_ARB_TIMEOUT_EN
    tmo_cnt_d    = '0;
    tmo_err_d    = tmo_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (req[owner_q] && !full_next) begin
          accept       = 1'b1;
          ack[owner_q] = 1'b1;
          fifo_wr_en_d = 1'b1;
          fifo_din_d   = din_arr[owner_q];
          if (last[owner_q]) begin
            rr_ptr_d = owner_inc;
            state_d  = IDLE;
          end
        end
`ifdef FIFO_ARB_TIMEOUT_EN
        // Only a silent owner counts towards the timeout; a full stall does not.
        if (!req[owner_q]) begin
          if (tmo_cnt_q == TW'(TMO - 1)) begin
            rr_ptr_d  = owner_inc;
            state_d   = IDLE;
            tmo_err_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    level_d = level_q;
    case ({accept, rd_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    udf_err_d = udf_err_q | (fifo_rd_en & (level_q == '0));
  end

  // All state lives in one register bank with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      level_q      <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_din_q   <= '0;
      udf_err_q    <= 1'b0;
`ifdef FIFO_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      tmo_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      level_q      <= level_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      fifo_din_q   <= fifo_din_d;
      udf_err_q    <= udf_err_d;
`ifdef FIFO_ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      tmo_err_q    <= tmo_err_d;
`endif
    end
  end

  assign fifo_wr_en = fifo_wr_en_q;
  assign fifo_din   = fifo_din_q;
  assign level      = level_q;
  assign empty      = (level_q == '0);
  assign full       = full_now;
  assign udf_err    = udf_err_q;
`ifdef FIFO_ARB_TIMEOUT_EN
  assign tmo_err    = tmo_err_q;
`else
  assign tmo_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_16_wr_arb.sv
// Directed bench for fifo_16_wr_arb: per-requester word queues drive the
// DUT, a scoreboard of expected FIFO write words is checked on fifo_wr_en.
module tb_fifo_16_wr_arb;
  localparam int NREQ = 4;
  localparam int AW   = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0, last = '0, ack;
  logic [NREQ*AW-1:0] din = '0;
  logic              fifo_wr_en, fifo_rd_en = 1'b0;
  logic [AW-1:0]     fifo_din;
  logic [9:0]        level;
  logic              empty, full, udf_err, tmo_err;

  fifo_16_wr_arb dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .din(din), .ack(ack),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
    .level(level), .empty(empty), .full(full), .udf_err(udf_err), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  logic [AW-1:0] wd [NREQ][1024];
  logic          wl [NREQ][1024];
  int            head [NREQ];
  int            tail [NREQ];
  logic [NREQ-1:0] en_mask = '1;
  logic          rd_tb = 1'b0;
  logic [NREQ-1:0] last_ack = '0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] exp_w;
  int            n_assert = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Queue a word for requester k; push it to the scoreboard if it should reach the FIFO.
  task automatic load(input int k, input logic [AW-1:0] d, input logic l, input logic push);
    wd[k][tail[k]] = d;
    wl[k][tail[k]] = l;
    tail[k]++;
    if (push) exp_q.push_back(d);
  endtask

  function automatic logic pending();
    logic p = 1'b0;
    for (int k = 0; k < NREQ; k++) if (en_mask[k] && head[k] < tail[k]) p = 1'b1;
    return p;
  endfunction

  // One clock: present queue heads, sample ack at negedge, advance acked heads.
  task automatic step();
    logic [NREQ-1:0] a;
    for (int k = 0; k < NREQ; k++) begin
      req[k] = en_mask[k] && (head[k] < tail[k]);
      din[k*AW +: AW] = req[k] ? wd[k][head[k]] : '0;
      last[k] = req[k] ? wl[k][head[k]] : 1'b0;
    end
    fifo_rd_en = rd_tb;
    @(negedge clk);
    a = ack;
    last_ack = a;
    n_assert++;
    assert ($onehot0(a) && ((a & ~req) == '0)) else begin
      n_fail++;
      $error("FAIL ack_onehot observed=%b expected=onehot0_within req=%b", a, req);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++) if (a[k]) head[k]++;
  endtask

  task automatic drain(input int bound, input string tag);
    int n = 0;
    while (pending() && n < bound) begin
      step();
      n++;
    end
    chk(tag, 32'(pending()), 32'd0);
  endtask

  // Scoreboard: every FIFO write must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && fifo_wr_en) begin
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL wr_unexpected observed=%0h expected=none", fifo_din);
      end else begin
        exp_w = exp_q.pop_front();
        assert (fifo_din === exp_w) else begin
          n_fail++;
          $error("FAIL wr_data observed=%0h expected=%0h", fifo_din, exp_w);
        end
      end
    end
  end

  initial begin
    int n;
    for (int k = 0; k < NREQ; k++) begin head[k] = 0; tail[k] = 0; end

    // Reset with all requesters pending, one-word packets each.
    load(0, 9'h010, 1'b1, 1'b1);
    load(1, 9'h011, 1'b1, 1'b1);
    load(2, 9'h012, 1'b1, 1'b1);
    load(3, 9'h013, 1'b1, 1'b1);
    repeat (3) begin
      step();
      chk("rst_ack", 32'(last_ack), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("first_cycle_ack", 32'(last_ack), 32'd0);
    step();
    chk("second_cycle_ack", 32'(last_ack), 32'b0001);
    drain(50, "drain_rr4");
    chk("level_after_rr4", 32'(level), 32'd4);

    // Three-word packet on 0 and one-word packet on 2, both pending.
    load(0, 9'h0A0, 1'b0, 1'b1);
    load(0, 9'h0A1, 1'b0, 1'b1);
    load(0, 9'h0A2, 1'b1, 1'b1);
    load(2, 9'h0C0, 1'b1, 1'b1);
    drain(50, "drain_pkt_a_c");
    // rr_ptr now 3: requester 3 must win over 0.
    load(3, 9'h0D0, 1'b1, 1'b1);
    load(0, 9'h0B0, 1'b1, 1'b1);
    drain(50, "drain_pkt_d_b");
    chk("level_10", 32'(level), 32'd10);

    // Empty the FIFO, then read once more to underflow.
    rd_tb = 1'b1;
    repeat (10) step();
    rd_tb = 1'b0;
    chk("level_0", 32'(level), 32'd0);
    chk("empty_0", 32'(empty), 32'd1);
    chk("udf_before", 32'(udf_err), 32'd0);
    rd_tb = 1'b1;
    step();
    rd_tb = 1'b0;
    chk("udf_set", 32'(udf_err), 32'd1);
    chk("udf_level", 32'(level), 32'd0);
    step();
    chk("udf_sticky", 32'(udf_err), 32'd1);

    // Fill to DEPTH with a 513-word packet from requester 1.
    for (int i = 0; i < 513; i++) load(1, 9'(i) ^ 9'h155, (i == 512), 1'b1);
    n = 0;
    while (level != 10'd512 && n < 700) begin step(); n++; end
    chk("fill_level", 32'(level), 32'd512);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_empty", 32'(empty), 32'd0);
    repeat (4) begin
      step();
      chk("stall_ack", 32'(last_ack), 32'd0);
      chk("stall_level", 32'(level), 32'd512);
    end
    rd_tb = 1'b1;
    step();
    rd_tb = 1'b0;
    chk("rd_full_ack", 32'(last_ack), 32'b0010);
    chk("rd_full_level", 32'(level), 32'd512);
    chk("fill_pkt_done", 32'(tail[1] - head[1]), 32'd0);

    // Drain to 100, then accept and read in the same cycle.
    rd_tb = 1'b1;
    repeat (412) step();
    rd_tb = 1'b0;
    chk("level_100", 32'(level), 32'd100);
    load(2, 9'h0E0, 1'b1, 1'b1);
    step();
    rd_tb = 1'b1;
    step();
    rd_tb = 1'b0;
    chk("wr_rd_ack", 32'(last_ack), 32'b0100);
    chk("wr_rd_level", 32'(level), 32'd100);
    chk("udf_still", 32'(udf_err), 32'd1);

    // Reset mid-packet with owner 1 and level 37.
    rd_tb = 1'b1;
    repeat (65) step();
    rd_tb = 1'b0;
    load(1, 9'h1F0, 1'b0, 1'b1);
    load(1, 9'h1F1, 1'b0, 1'b0);
    load(1, 9'h1F2, 1'b0, 1'b0);
    load(1, 9'h1F3, 1'b1, 1'b0);
    step();
    step();
    step();
    chk("mid_level", 32'(level), 32'd37);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("arst_din", 32'(fifo_din), 32'd0);
    chk("arst_udf", 32'(udf_err), 32'd0);
    chk("arst_tmo", 32'(tmo_err), 32'd0);
    for (int k = 0; k < NREQ; k++) head[k] = tail[k];
    step();
    step();
    load(0, 9'h0B1, 1'b1, 1'b1);
    load(3, 9'h0D1, 1'b1, 1'b1);
    rst_n = 1'b1;
    drain(50, "drain_after_reset");
    chk("level_after_reset", 32'(level), 32'd2);

    // Owner 1 goes silent mid-packet while requester 2 waits.
    load(1, 9'h111, 1'b0, 1'b1);
    load(1, 9'h112, 1'b0, 1'b0);
    load(1, 9'h113, 1'b1, 1'b0);
    load(2, 9'h122, 1'b1, 1'b0);
    step();
    step();
    chk("tmo_first_ack", 32'(last_ack), 32'b0010);
    en_mask[1] = 1'b0;
`ifdef FIFO_ARB_TIMEOUT_EN
    exp_q.push_back(9'h122);
    n = 0;
    while (head[2] < tail[2] && n < 200) begin step(); n++; end
    chk("tmo_grant_cycles", 32'(n), 32'd66);
    chk("tmo_err_set", 32'(tmo_err), 32'd1);
    head[1] = tail[1];
    en_mask = '1;
`else
    n = 0;
    repeat (100) begin
      step();
      if (last_ack != '0) n++;
    end
    chk("hold_no_ack", 32'(n), 32'd0);
    chk("hold_tmo_err", 32'(tmo_err), 32'd0);
    en_mask = '1;
    exp_q.push_back(9'h112);
    exp_q.push_back(9'h113);
    exp_q.push_back(9'h122);
    drain(50, "drain_after_hold");
`endif

    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_16_wr_arb.md
Name: fifo_16_wr_arb

Overview:
- Packet-granular round-robin arbiter that shares the single write port of one fifo_16 instance among NREQ ingress requesters in the GSM switch.
- fifo_16 exposes no usable full/empty flags, so this block keeps its own occupancy count.
- It never writes into a full FIFO and never interleaves words from different packets.
- The consumer's read strobe is tapped in for the occupancy count; the block does not drive the FIFO read side.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AWIDTH, 9, data word width; matches the fifo_16 AWIDTH.
- DEPTH, 512, FIFO capacity in words.
- LVLW, 10, occupancy counter width; must satisfy 2^LVLW > DEPTH.
- TMO, 64, idle-owner timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester word valid.
- last  in  NREQ  per-requester end-of-packet marker, qualified by req.
- din  in  NREQ*AWIDTH  requester data; requester k occupies bits [k*AWIDTH +: AWIDTH].
- ack  out  NREQ  word accepted this cycle; combinational, at most one bit set.
- fifo_wr_en  out  1  registered write strobe to fifo_16.
- fifo_din  out  AWIDTH  registered write data to fifo_16.
- fifo_rd_en  in  1  copy of the consumer's rd_en into fifo_16.
- level  out  LVLW  FIFO occupancy in words.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- udf_err  out  1  sticky: fifo_rd_en was seen while level==0.
- tmo_err  out  1  sticky: owner timeout (optional feature only).

Behaviour:
- Async reset values:
  - State IDLE; owner=0; rr_ptr=0.
  - level=0, empty=1, full=0.
  - fifo_wr_en=0, fifo_din=0.
  - ack=0, udf_err=0, tmo_err=0, timeout counter=0.
- IDLE state:
  - If any req is high, pick the first requester with req high, searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - Register the winner as owner and go to BUSY next cycle.
  - No word is accepted in IDLE. Every packet therefore costs one arbitration bubble cycle.
- BUSY state:
  - accept = req[owner] & ~full_next, where full_next means level==DEPTH and no read is in flight this cycle.
  - A read-while-full frees space in the same cycle.
  - On accept: ack[owner]=1, and the word is registered to fifo_din with fifo_wr_en=1 next cycle. Write latency is 1 cycle.
  - Accepting a word with last[owner]=1: set rr_ptr=(owner+1) mod NREQ and go to IDLE.
  - While full, or while req[owner] is low: hold the grant and stall. Other requesters' req are ignored.
- Level accounting:
  - level is updated in the same cycle as an accept.
  - Write only: +1. Read only: -1. Both: unchanged.
  - A read with level==0 does not decrement; it sets udf_err.
  - level never exceeds DEPTH.
- A one-word packet (req and last high together) costs 2 cycles: 1 in IDLE, 1 in BUSY.
- The din/last of non-owners are don't-care.
- Requesters must keep req, din and last stable until they see ack.

Optional Feature:
- Macro: FIFO_ARB_TIMEOUT_EN.
- Defined:
  - In BUSY, count consecutive cycles with req[owner]=0. The count resets on any cycle with req[owner]=1.
  - On reaching TMO: force IDLE, advance rr_ptr past owner, set tmo_err.
  - The partial packet already written stays in the FIFO.
- Undefined:
  - No counter is built; tmo_err is tied to 0.
  - An owner can hold the grant indefinitely.

Test Plan:
- Reset with req=4'b1111 held → ack=0, level=0, empty=1 throughout reset. After release: owner=0 granted, first ack in the 2nd cycle after rst_n rises.
- req[0] sends a 3-word packet and req[2] a 1-word packet, both pending → FIFO receives the three req[0] words A0,A1,A2, then C0. Next grant goes to requester 3 if requesting, otherwise wraps to 0.
- Fill with 512 writes, no reads → full=1, level=512. Further req is stalled with ack=0. Assert fifo_rd_en once → the one stalled word is accepted that cycle; level stays 512.
- Simultaneous accept and fifo_rd_en at level=100 → level stays 100. fifo_rd_en at level=0 → level stays 0, udf_err=1 and stays set.
- Pulse rst_n low mid-packet (owner=1, level=37) → all outputs return to reset values asynchronously. After release, arbitration restarts from requester 0.
- FIFO_ARB_TIMEOUT_EN defined, TMO=64: owner drops req mid-packet for 64 cycles → tmo_err=1, state returns to IDLE, next requester granted. With the macro undefined, the grant is held forever.
